// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants, FSM state type and commit-info layout for the IFU
package ifu_pkg;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  localparam int CI_W          = 161;
  localparam int CI_COMMIT_BIT = 160;
  localparam int CI_PC_LSB     = 96;
  localparam int CI_INSTR_LSB  = 64;
  localparam int CI_PRE_PC_LSB = 0;

  // Field order matches the bit offsets above, MSB first.
  typedef struct packed {
    logic        commit;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] pre_pc;
  } commit_info_t;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - fetch PC register, redirect handling and stale-response drop flag
module ifu_pc_gen #(
  parameter logic [63:0] RESET_PC = ifu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req_i,
  input  logic        in_wait_i,
  input  logic        resp_valid_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic [63:0] fetch_pc_o,
  output logic [63:0] fetch_pc_next_o,
  output logic        drop_o
);
  import ifu_pkg::*;

  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic        wait_resp;

  assign wait_resp = in_wait_i && resp_valid_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
    end else if (wait_resp && !drop_q) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
    // A response always retires the single outstanding request, so nothing is left to drop.
    if (wait_resp) begin
      drop_d = 1'b0;
    end else if (redirect_valid_i && (in_req_i || in_wait_i)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  assign fetch_pc_o      = fetch_pc_q;
  assign fetch_pc_next_o = fetch_pc_d;
  assign drop_o          = drop_q;

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: single-outstanding imem fetch FSM and fetch/decode output registers
module ifu #(
  parameter logic [63:0] RESET_PC = ifu_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         regD_stall,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [63:0]  imem_req_addr,
  input  logic         imem_resp_valid,
  input  logic [31:0]  imem_resp_data,
  output logic         fetch_o_valid,
  output logic [63:0]  fetch_o_pc,
  output logic [31:0]  fetch_o_instr,
  output logic [160:0] fetch_o_commit_info
);
  import ifu_pkg::*;

  ifu_state_e   state_q, state_d;
  logic         valid_q, valid_d;
  logic [63:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [63:0]  pre_pc_q, pre_pc_d;
  logic [63:0]  req_addr_q, req_addr_d;
  logic [63:0]  fetch_pc, fetch_pc_next;
  logic         drop;
  logic         accept;
  commit_info_t commit_info;

  ifu_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk             (clk),
    .rst             (rst),
    .in_req_i        (state_q == REQ),
    .in_wait_i       (state_q == WAIT),
    .resp_valid_i    (imem_resp_valid),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .fetch_pc_o      (fetch_pc),
    .fetch_pc_next_o (fetch_pc_next),
    .drop_o          (drop)
  );

  // A redirect arriving with the response makes that response stale as well.
  assign accept = (state_q == WAIT) && imem_resp_valid && !drop && !redirect_valid;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pre_pc_d = pre_pc_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        state_d = REQ;
      end
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (accept) begin
          valid_d = 1'b1;
          pc_d    = req_addr_q;
          instr_d = imem_resp_data;
          state_d = OUT;
        end else if (imem_resp_valid) begin
          state_d = REQ;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          state_d = REQ;
        end else if (!regD_stall) begin
          pre_pc_d = pc_q;
          valid_d  = 1'b0;
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The request address is latched on REQ entry so a redirect during REQ cannot disturb it.
  assign req_addr_d = (state_d == REQ && state_q != REQ) ? fetch_pc_next : req_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      pre_pc_q   <= '0;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pre_pc_q   <= pre_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = req_addr_q;
  assign fetch_o_valid  = valid_q;
  assign fetch_o_pc     = pc_q;
  assign fetch_o_instr  = instr_q;

  assign commit_info.commit = valid_q;
  assign commit_info.pc     = pc_q;
  assign commit_info.instr  = instr_q;
  assign commit_info.pre_pc = pre_pc_q;
  assign fetch_o_commit_info = commit_info;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed self-checking bench for the ifu fetch unit
module tb_ifu;

  logic         clk;
  logic         rst;
  logic         regD_stall;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [63:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic         fetch_o_valid;
  logic [63:0]  fetch_o_pc;
  logic [31:0]  fetch_o_instr;
  logic [160:0] fetch_o_commit_info;

  int errors = 0;
  int checks = 0;

  ifu dut (
    .clk                (clk),
    .rst                (rst),
    .regD_stall         (regD_stall),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_resp_valid    (imem_resp_valid),
    .imem_resp_data     (imem_resp_data),
    .fetch_o_valid      (fetch_o_valid),
    .fetch_o_pc         (fetch_o_pc),
    .fetch_o_instr      (fetch_o_instr),
    .fetch_o_commit_info(fetch_o_commit_info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [160:0] obs, input logic [160:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait for a request, accept it, return the response one cycle later.
  task automatic do_fetch(input logic [31:0] data, output logic [63:0] addr, output int waits);
    waits = 0;
    while (!imem_req_valid && waits < 20) begin
      step();
      waits++;
    end
    check("req_seen", imem_req_valid, 1'b1);
    addr = imem_req_addr;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] addr;
    int          waits;

    rst             = 1'b0;
    regD_stall      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    step();
    step();
    check("rst_valid", fetch_o_valid, 1'b0);
    check("rst_pc", fetch_o_pc, 64'h0);
    check("rst_commit", fetch_o_commit_info, 161'h0);
    check("rst_req_valid", imem_req_valid, 1'b0);

    rst = 1'b1;
    do_fetch(32'h0000_0013, addr, waits);
    check("f1_addr", addr, 64'h8000_0000);
    check("f1_wait", waits, 1);
    check("f1_valid", fetch_o_valid, 1'b1);
    check("f1_pc", fetch_o_pc, 64'h8000_0000);
    check("f1_instr", fetch_o_instr, 32'h0000_0013);
    check("f1_commit", fetch_o_commit_info, {1'b1, 64'h8000_0000, 32'h0000_0013, 64'h0});

    do_fetch(32'h0010_0093, addr, waits);
    check("f2_wait", waits, 1);
    check("f2_pc", fetch_o_pc, 64'h8000_0004);
    check("f2_commit", fetch_o_commit_info, {1'b1, 64'h8000_0004, 32'h0010_0093, 64'h8000_0000});

    do_fetch(32'h0020_0113, addr, waits);
    regD_stall = 1'b1;
    check("f3_wait", waits, 1);
    check("f3_commit", fetch_o_commit_info, {1'b1, 64'h8000_0008, 32'h0020_0113, 64'h8000_0004});

    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_commit", fetch_o_commit_info, {1'b1, 64'h8000_0008, 32'h0020_0113, 64'h8000_0004});
      check("stall_no_req", imem_req_valid, 1'b0);
    end

    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    step();
    redirect_valid = 1'b0;
    check("rdo_valid", fetch_o_valid, 1'b0);
    check("rdo_req_valid", imem_req_valid, 1'b1);
    check("rdo_req_addr", imem_req_addr, 64'h8000_2000);
    regD_stall = 1'b0;

    do_fetch(32'h0030_0193, addr, waits);
    check("f4_addr", addr, 64'h8000_2000);
    check("f4_pc", fetch_o_pc, 64'h8000_2000);
    check("f4_valid", fetch_o_valid, 1'b1);

    step();
    check("seq_addr", imem_req_addr, 64'h8000_2004);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    step();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    check("drop_valid", fetch_o_valid, 1'b0);
    check("drop_req_valid", imem_req_valid, 1'b1);
    check("drop_req_addr", imem_req_addr, 64'h8000_1000);

    do_fetch(32'h0040_0213, addr, waits);
    check("f5_addr", addr, 64'h8000_1000);
    check("f5_pc", fetch_o_pc, 64'h8000_1000);
    check("f5_instr", fetch_o_instr, 32'h0040_0213);

    step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_F00D;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_3000;
    step();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    check("coin_valid", fetch_o_valid, 1'b0);
    check("coin_req_addr", imem_req_addr, 64'h8000_3000);

    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_1111;
    step();
    imem_resp_valid = 1'b0;
    check("ign_valid", fetch_o_valid, 1'b0);
    check("ign_req_valid", imem_req_valid, 1'b1);
    check("ign_pc", fetch_o_pc, 64'h8000_1000);

    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait_no_req", imem_req_valid, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("arst_pc", fetch_o_pc, 64'h0);
    check("arst_instr", fetch_o_instr, 32'h0);
    check("arst_commit", fetch_o_commit_info, 161'h0);
    check("arst_req_valid", imem_req_valid, 1'b0);
    step();
    rst             = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    step();
    imem_resp_valid = 1'b0;
    check("post_rst_valid", fetch_o_valid, 1'b0);
    check("post_rst_req_valid", imem_req_valid, 1'b1);
    check("post_rst_addr", imem_req_addr, 64'h8000_0000);

    do_fetch(32'h0000_0013, addr, waits);
    check("f6_commit", fetch_o_commit_info, {1'b1, 64'h8000_0000, 32'h0000_0013, 64'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, 64'h0000_0000_8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single rising-edge clock.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 regD_stall  input  1  SHALL indicate the fetch/decode register is holding and not capturing this cycle.
REQ-005 redirect_valid  input  1  SHALL request a fetch redirect (branch/jump/trap) this cycle.
REQ-006 redirect_pc  input  64  SHALL give the redirect target.
REQ-007 imem_req_valid  output  1  SHALL flag an instruction-memory read request.
REQ-008 imem_req_ready  input  1  SHALL accept the request when high together with imem_req_valid.
REQ-009 imem_req_addr  output  64  SHALL carry the request address.
REQ-010 imem_resp_valid  input  1  SHALL flag returned instruction data.
REQ-011 imem_resp_data  input  32  SHALL carry the returned instruction.
REQ-012 fetch_o_valid  output  1  SHALL mark fetch_o_* as a real instruction.
REQ-013 fetch_o_pc  output  64  SHALL give the delivered instruction's PC.
REQ-014 fetch_o_instr  output  32  SHALL give the delivered instruction.
REQ-015 fetch_o_commit_info  output  161  SHALL pack {commit[160], pc[159:96], instr[95:64], pre_pc[63:0]}.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, OUT. After reset the FSM SHALL be in IDLE, and on the next edge it SHALL move IDLE->REQ.
REQ-017 REQ behaviour: imem_req_valid=1 and imem_req_addr=fetch_pc; addr SHALL stay stable until handshake; on imem_req_ready it SHALL go to WAIT.
REQ-018 WAIT with imem_resp_valid and no drop: the output registers SHALL load {pc, instr}, fetch_o_valid SHALL go to 1, fetch_pc SHALL advance by 4 (modulo 2^64), and the FSM SHALL go to OUT.
REQ-019 OUT behaviour: while regD_stall=1 the outputs SHALL hold unchanged; when regD_stall=0, at the edge pre_pc SHALL become fetch_o_pc, fetch_o_valid SHALL go to 0, and the FSM SHALL go to REQ.
REQ-020 commit bit SHALL equal fetch_o_valid; pre_pc SHALL be the PC of the previously delivered instruction, and SHALL be 0 before the first one.
REQ-021 Redirect in IDLE or OUT: fetch_pc SHALL be set to redirect_pc, fetch_o_valid SHALL go to 0, and the FSM SHALL go to REQ; redirect has priority over regD_stall.
REQ-022 Redirect in REQ (before or at handshake) or in WAIT: fetch_pc SHALL be set to redirect_pc, and the drop flag SHALL be set; the in-flight request SHALL complete normally.
REQ-023 Redirect coincident with imem_resp_valid in WAIT: that response SHALL be dropped.
REQ-024 WAIT with imem_resp_valid and drop=1: the response SHALL be discarded, drop SHALL clear, and the FSM SHALL go to REQ at fetch_pc.
REQ-025 redirect_pc[1:0] SHALL be forced to 2'b00; at most one request SHALL be outstanding.
REQ-026 imem_resp_valid outside WAIT SHALL be ignored.
REQ-027 Minimum delivery interval: one instruction per 3 cycles with zero-wait memory and no stall.

Reset
REQ-028 While rst=0, and asynchronously on assertion, the following SHALL reset: FSM=IDLE, fetch_pc=RESET_PC, drop=0, fetch_o_valid=0, fetch_o_pc=0, fetch_o_instr=0, pre_pc=0, imem_req_valid=0.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; the first response after deassertion, if any, SHALL be ignored unless the FSM is in WAIT.

Structure
REQ-030 The shared package SHALL hold RESET_PC, the FSM state enum, and the commit_info field offsets/width (161).
REQ-031 The block SHALL contain one sub-module, ifu_pc_gen (fetch_pc, drop flag, redirect handling); the FSM and output registers SHALL be in ifu.

Verification
REQ-032 Reset release, ready=1, resp 1 cycle later with data 32'h00000013 -> fetch_o_valid=1, pc=8000_0000, commit_info={1,8000_0000,00000013,0}.
REQ-033 Three back-to-back fetches, no stall -> pcs 8000_0000/8000_0004/8000_0008, pre_pc of the third = 8000_0004.
REQ-034 regD_stall=1 for 5 cycles in OUT -> outputs constant; no imem request issued.
REQ-035 Redirect to 8000_1002 in WAIT -> the response is dropped, the next request addr = 8000_1000, and no fetch_o_valid for the dropped data.
REQ-036 Redirect together with regD_stall=1 in OUT -> fetch_o_valid=0 next cycle, the next request addr = redirect target.
REQ-037 rst=0 asserted while in WAIT -> outputs 0 immediately (asynchronous); after release, the first request addr = 8000_0000.
